// File: rtl/alu_seq.sv
// alu_seq: sequential ALU sitting between register-file read and writeback.
//   Single-cycle logic/arith/shift/compare ops, plus iterative shift-add
//   multiply (low/high half) and restoring unsigned divide (quotient/remainder),
//   one iteration per cycle for WIDTH cycles.
// Ports:
//   clk, rstn              clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready    operand handshake; in_ready is high only in IDLE
//   a, b, f                operands and 4-bit op code, captured on accept
//   out_valid / out_ready  result handshake
//   y, z, dz               result, zero flag, divide-by-zero flag
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             dz
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_opnd;    // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0] r_hi;      // product high half / partial remainder
  logic [WIDTH-1:0] r_lo;      // multiplier bits / dividend-then-quotient
  logic             r_is_div;
  logic             r_sel_hi;  // result is the high register (ops 9, 11)
  logic [WIDTH-1:0] r_y;
  logic             r_z;
  logic             r_dz;
  logic             r_out_valid;

  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_alu;
  logic             w_is_iter;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shf;
  logic [WIDTH-1:0] w_div_sub;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_hi_nx;
  logic [WIDTH-1:0] w_lo_nx;
  logic [WIDTH-1:0] w_res;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign z         = r_z;
  assign dz        = r_dz;

  // Ops 8..11 take the iterative path.
  assign w_is_iter = (f[3:2] == 2'b10);
  assign w_sh      = b[SHW-1:0];

  // Single-cycle result, evaluated on the live inputs at accept time.
  always_comb begin
    w_alu = '0;
    case (f)
      4'd0:    w_alu = a & b;
      4'd1:    w_alu = a | b;
      4'd2:    w_alu = a + b;
      4'd3:    w_alu = a ^ b;
      4'd4:    w_alu = a << w_sh;
      4'd5:    w_alu = a >> w_sh;
      4'd6:    w_alu = a - b;
      4'd7:    w_alu = WIDTH'(a < b);
      4'd12:   w_alu = ~(a | b);
      4'd13:   w_alu = WIDTH'($signed(a) >>> w_sh);
      4'd14:   w_alu = WIDTH'($signed(a) < $signed(b));
      default: w_alu = '0;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  // With a zero divisor every trial subtract succeeds, so the quotient
  // saturates to all ones and the remainder ends up equal to the dividend.
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + {1'b0, r_opnd};
    if (!r_lo[0]) begin
      w_mul_sum = {1'b0, r_hi};
    end
    w_div_shf = {r_hi, r_lo[WIDTH-1]};
    w_div_ge  = (w_div_shf >= {1'b0, r_opnd});
    w_div_sub = w_div_shf[WIDTH-1:0] - r_opnd;
    if (r_is_div) begin
      w_hi_nx = w_div_ge ? w_div_sub : w_div_shf[WIDTH-1:0];
      w_lo_nx = {r_lo[WIDTH-2:0], w_div_ge};
    end else begin
      w_hi_nx = w_mul_sum[WIDTH:1];
      w_lo_nx = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
    w_res = r_sel_hi ? w_hi_nx : w_lo_nx;
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_opnd      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_is_div    <= 1'b0;
      r_sel_hi    <= 1'b0;
      r_y         <= '0;
      r_z         <= 1'b1;
      r_dz        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_is_iter) begin
              r_state  <= S_BUSY;
              r_cnt    <= '0;
              r_is_div <= f[1];
              r_sel_hi <= f[0];
              r_opnd   <= f[1] ? b : a;
              r_lo     <= f[1] ? a : b;
              r_hi     <= '0;
            end else begin
              r_state     <= S_DONE;
              r_y         <= w_alu;
              r_z         <= (w_alu == '0);
              r_dz        <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt + SHW'(1);
          if (r_cnt == SHW'(WIDTH - 1)) begin
            r_state     <= S_DONE;
            r_y         <= w_res;
            r_z         <= (w_res == '0);
            r_dz        <= r_is_div && (r_opnd == '0);
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=32). Random operands are
// checked against a plain-arithmetic reference model; fixed vectors cover the
// corner cases, latency, backpressure and reset in the middle of an operation.
module tb_alu_seq;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  f;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        z;
  logic        dz;

  int n_cmp;
  int n_err;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .f         (f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .z         (z),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // Reference model: returns {dz, y}.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] av,
                                        input logic [31:0] bv);
    logic [63:0] p;
    logic [31:0] r;
    logic        d;
    int          sh;
    sh = int'(bv % 32);
    p  = 64'(av) * 64'(bv);
    d  = 1'b0;
    case (op)
      4'd0:  r = av & bv;
      4'd1:  r = av | bv;
      4'd2:  r = av + bv;
      4'd3:  r = av ^ bv;
      4'd4:  r = av << sh;
      4'd5:  r = av >> sh;
      4'd6:  r = av - bv;
      4'd7:  r = (av < bv) ? 32'd1 : 32'd0;
      4'd8:  r = p[31:0];
      4'd9:  r = p[63:32];
      4'd10: begin if (bv == 0) begin r = 32'hFFFF_FFFF; d = 1'b1; end else r = av / bv; end
      4'd11: begin if (bv == 0) begin r = av; d = 1'b1; end else r = av % bv; end
      4'd12: r = ~(av | bv);
      4'd13: r = 32'($signed(av) >>> sh);
      4'd14: r = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {d, r};
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    return (op >= 4'd8 && op <= 4'd11) ? 33 : 1;
  endfunction

  // Drive one op from IDLE (called #1 after a rising edge), wait for the
  // result, capture it, then complete the output handshake.
  task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] ry, output logic rz, output logic rdz,
                        output int lat);
    int cyc;
    in_valid = 1'b1; f = op; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; f = 4'($urandom);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    lat = (out_valid === 1'b1) ? cyc : -1;
    ry = y; rz = z; rdz = dz;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; f = '0;
    #12;
    n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (y !== 32'd0)        begin n_err++; $display("FAIL reset_y got=%h exp=0", y); end
    n_cmp++; if (z !== 1'b1)         begin n_err++; $display("FAIL reset_z got=%b exp=1", z); end
    n_cmp++; if (dz !== 1'b0)        begin n_err++; $display("FAIL reset_dz got=%b exp=0", dz); end
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({in_ready, out_valid, y, z, dz} !== {1'b1, 1'b0, 32'd0, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d got rdy=%b vld=%b y=%h z=%b dz=%b exp 1 0 0 1 0",
                 i, in_ready, out_valid, y, z, dz);
      end
    end
  endtask

  task automatic test_single();
    logic [31:0] ry, av, bv; logic rz, rdz; int lat; logic [3:0] op; logic [32:0] e;
    run_op(4'd2, 32'hFFFF_FFFF, 32'd1, ry, rz, rdz, lat);
    n_cmp++; if (ry !== 32'd0) begin n_err++; $display("FAIL add_wrap_y got=%h exp=0", ry); end
    n_cmp++; if (rz !== 1'b1)  begin n_err++; $display("FAIL add_wrap_z got=%b exp=1", rz); end
    n_cmp++; if (lat !== 1)    begin n_err++; $display("FAIL add_lat got=%0d exp=1", lat); end
    run_op(4'd13, 32'h8000_0000, 32'h0000_0021, ry, rz, rdz, lat);
    n_cmp++; if (ry !== 32'hC000_0000) begin n_err++; $display("FAIL sra_y got=%h exp=C0000000", ry); end
    n_cmp++; if (rz !== 1'b0) begin n_err++; $display("FAIL sra_z got=%b exp=0", rz); end
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op >= 4'd8 && op <= 4'd11) op = op + 4'd4;
      av = $urandom; bv = (i % 3 == 0) ? av : $urandom;
      if (i % 4 == 1) bv = $urandom_range(0, 63);
      e = model(op, av, bv);
      run_op(op, av, bv, ry, rz, rdz, lat);
      n_cmp++;
      if (ry !== e[31:0] || rz !== (e[31:0] == 0) || rdz !== 1'b0 || lat !== 1) begin
        n_err++;
        $display("FAIL single f=%0d a=%h b=%h got y=%h z=%b dz=%b lat=%0d exp y=%h z=%b dz=0 lat=1",
                 op, av, bv, ry, rz, rdz, lat, e[31:0], (e[31:0] == 0));
      end
    end
  endtask

  task automatic test_mul();
    logic [31:0] ry, av, bv; logic rz, rdz; int lat; logic [3:0] op; logic [32:0] e;
    run_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ry, rz, rdz, lat);
    n_cmp++; if (ry !== 32'h0000_0001) begin n_err++; $display("FAIL mul_lo_y got=%h exp=00000001", ry); end
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul_lo_lat got=%0d exp=33", lat); end
    run_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ry, rz, rdz, lat);
    n_cmp++; if (ry !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mul_hi_y got=%h exp=FFFFFFFE", ry); end
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul_hi_lat got=%0d exp=33", lat); end
    for (int i = 0; i < 8; i++) begin
      op = (i % 2 == 0) ? 4'd8 : 4'd9;
      av = $urandom; bv = (i == 2) ? 32'd0 : $urandom;
      e = model(op, av, bv);
      run_op(op, av, bv, ry, rz, rdz, lat);
      n_cmp++;
      if (ry !== e[31:0] || rz !== (e[31:0] == 0) || rdz !== 1'b0 || lat !== 33) begin
        n_err++;
        $display("FAIL mul f=%0d a=%h b=%h got y=%h z=%b dz=%b lat=%0d exp y=%h dz=0 lat=33",
                 op, av, bv, ry, rz, rdz, lat, e[31:0]);
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] ry, av, bv; logic rz, rdz; int lat; logic [3:0] op; logic [32:0] e;
    run_op(4'd10, 32'd100, 32'd7, ry, rz, rdz, lat);
    n_cmp++; if (ry !== 32'd14) begin n_err++; $display("FAIL divu_y got=%0d exp=14", ry); end
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL divu_lat got=%0d exp=33", lat); end
    run_op(4'd11, 32'd100, 32'd7, ry, rz, rdz, lat);
    n_cmp++; if (ry !== 32'd2) begin n_err++; $display("FAIL remu_y got=%0d exp=2", ry); end
    run_op(4'd10, 32'h1234_5678, 32'd0, ry, rz, rdz, lat);
    n_cmp++; if (ry !== 32'hFFFF_FFFF || rdz !== 1'b1 || lat !== 33) begin
      n_err++; $display("FAIL divu_zero got y=%h dz=%b lat=%0d exp y=FFFFFFFF dz=1 lat=33", ry, rdz, lat);
    end
    run_op(4'd11, 32'd5, 32'd0, ry, rz, rdz, lat);
    n_cmp++; if (ry !== 32'd5 || rdz !== 1'b1 || lat !== 33) begin
      n_err++; $display("FAIL remu_zero got y=%h dz=%b lat=%0d exp y=5 dz=1 lat=33", ry, rdz, lat);
    end
    for (int i = 0; i < 10; i++) begin
      op = (i % 2 == 0) ? 4'd10 : 4'd11;
      av = $urandom;
      bv = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 8) bv = av;
      e = model(op, av, bv);
      run_op(op, av, bv, ry, rz, rdz, lat);
      n_cmp++;
      if (ry !== e[31:0] || rz !== (e[31:0] == 0) || rdz !== e[32] || lat !== 33) begin
        n_err++;
        $display("FAIL div f=%0d a=%h b=%h got y=%h z=%b dz=%b lat=%0d exp y=%h dz=%b lat=33",
                 op, av, bv, ry, rz, rdz, lat, e[31:0], e[32]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] av, bv; logic [32:0] e;
    av = $urandom; bv = $urandom;
    e = model(4'd3, av, bv);
    in_valid = 1'b1; f = 4'd3; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_first_valid got=%b exp=1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      // Offer a competing op while the result is held; it must be ignored.
      if (i >= 2 && i <= 5) begin
        in_valid = 1'b1; f = 4'd0; a = 32'd0; b = 32'd0;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      n_cmp++;
      if (y !== e[31:0] || out_valid !== 1'b1 || in_ready !== 1'b0 || dz !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold cyc=%0d got y=%h vld=%b rdy=%b dz=%b exp y=%h vld=1 rdy=0 dz=0",
                 i, y, out_valid, in_ready, dz, e[31:0]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_phantom_op got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av, bv; logic [32:0] e; logic [3:0] op;
    for (int i = 0; i < 6; i++) begin
      op = 4'(i % 8); av = $urandom; bv = $urandom;
      e = model(op, av, bv);
      in_valid = 1'b1; f = op; a = av; b = bv;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== e[31:0]) begin
        n_err++;
        $display("FAIL b2b_result i=%0d got vld=%b rdy=%b y=%h exp vld=1 rdy=0 y=%h",
                 i, out_valid, in_ready, y, e[31:0]);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_idle i=%0d got vld=%b rdy=%b exp vld=0 rdy=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] ry; logic rz, rdz; int lat;
    in_valid = 1'b1; f = 4'd9; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, y, z, dz} !== {1'b1, 1'b0, 32'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL midop_reset got rdy=%b vld=%b y=%h z=%b dz=%b exp 1 0 0 1 0",
               in_ready, out_valid, y, z, dz);
    end
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    run_op(4'd0, 32'h0000_00F0, 32'h0000_003C, ry, rz, rdz, lat);
    n_cmp++;
    if (ry !== 32'h30 || rz !== 1'b0 || rdz !== 1'b0 || lat !== 1) begin
      n_err++;
      $display("FAIL midop_next got y=%h z=%b dz=%b lat=%0d exp y=30 z=0 dz=0 lat=1", ry, rz, rdz, lat);
    end
    repeat (40) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midop_residue got vld=%b exp=0", out_valid); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_mul();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
